// File: rtl/multi_adder_sum_if.sv
// Bus bundle for multi_adder_sum: packed feature inputs with valid qualifier,
// and the saturated result with its aligned valid.
//   d_in   : CL_IN*N packed signed features, feature i at d_in[i*N +: N]
//   en_in  : d_in valid this cycle
//   d_out  : N-bit signed result
//   en_out : one-cycle pulse per accepted en_in, aligned with d_out
interface multi_adder_sum_if #(
    parameter int unsigned CL_IN = 8,
    parameter int unsigned N     = 3
);
    logic [CL_IN*N-1:0] d_in;
    logic               en_in;
    logic [N-1:0]       d_out;
    logic               en_out;

    modport master (
        output d_in,
        output en_in,
        input  d_out,
        input  en_out
    );

    modport slave (
        input  d_in,
        input  en_in,
        output d_out,
        output en_out
    );
endinterface

// File: rtl/multi_adder_sum.sv
// Pipelined signed multi-input adder: registered binary adder tree over CL_IN
// features, arithmetic right shift by SR, optional ReLU, saturation to N bits.
// A valid flag travels alongside the data with the same latency (L_T + 1).
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of multi_adder_sum_if (d_in/en_in in, d_out/en_out out)
module multi_adder_sum #(
    parameter int unsigned CL_IN = 8,
    parameter int unsigned RELU  = 0,
    parameter int unsigned N     = 3,
    parameter int unsigned SR    = 2
) (
    input  logic               clk,
    input  logic               rst,
    multi_adder_sum_if.slave   bus
);
    localparam int unsigned L_T = $clog2(CL_IN);
    localparam int unsigned P   = 1 << L_T;
    localparam int unsigned W   = N + L_T;

    // Saturation bounds expressed at tree width; ~MAX is the most negative N-bit value
    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (N - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

    // Heap-ordered tree: index 1 is the root, children of k are 2k and 2k+1,
    // leaves occupy P..2P-1 (sign-extended inputs, zero padding beyond CL_IN).
    logic signed [W-1:0] heap_c [1:2*P-1];
    logic signed [W-1:0] sum_c;
    logic                post_en_c;

    for (genvar g = 0; g < P; g++) begin : gen_leaf
        if (g < CL_IN) begin : gen_in
            assign heap_c[P+g] = W'(signed'(bus.d_in[g*N +: N]));
        end else begin : gen_pad
            assign heap_c[P+g] = '0;
        end
    end

    // Registered adder levels; every internal node is one register deep per level
    if (L_T > 0) begin : gen_tree
        logic signed [W-1:0] node_q [1:P-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 1; i < P; i++) begin
                    node_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 1; i < P; i++) begin
                    node_q[i] <= heap_c[2*i] + heap_c[2*i+1];
                end
            end
        end

        for (genvar g = 1; g < P; g++) begin : gen_link
            assign heap_c[g] = node_q[g];
        end

        assign sum_c = node_q[1];
    end else begin : gen_no_tree
        assign sum_c = heap_c[1];
    end

    // Valid shift register matching the tree depth
    if (L_T > 0) begin : gen_en
        logic [L_T-1:0] en_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                en_q <= '0;
            end else begin
                en_q[0] <= bus.en_in;
                for (int unsigned i = 1; i < L_T; i++) begin
                    en_q[i] <= en_q[i-1];
                end
            end
        end

        assign post_en_c = en_q[L_T-1];
    end else begin : gen_no_en
        assign post_en_c = bus.en_in;
    end

    // Post stage: shift, optional ReLU, saturate
    logic signed [W-1:0] shr_c;
    logic signed [N-1:0] sat_c;

    assign shr_c = sum_c >>> SR;

    always_comb begin
        sat_c = N'(shr_c);
        if ((RELU != 0) && (shr_c < 0)) begin
            sat_c = '0;
        end else if (shr_c > SAT_MAX) begin
            sat_c = N'(SAT_MAX);
        end else if (shr_c < SAT_MIN) begin
            sat_c = N'(SAT_MIN);
        end
    end

    // Output register holds its value between valid results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.d_out  <= '0;
            bus.en_out <= 1'b0;
        end else begin
            bus.en_out <= post_en_c;
            if (post_en_c) begin
                bus.d_out <= sat_c;
            end
        end
    end
endmodule

// File: tb/tb_multi_adder_sum.sv
// Directed bench for multi_adder_sum (CL_IN=8, N=3, SR=2); one DUT with
// RELU=0 and one with RELU=1 share the same stimulus.
module tb_multi_adder_sum;
    localparam int unsigned CL_IN = 8;
    localparam int unsigned N     = 3;

    logic               clk;
    logic               rst;
    logic [CL_IN*N-1:0] d_in;
    logic               en_in;

    int n_checks;
    int n_fails;

    multi_adder_sum_if #(.CL_IN(CL_IN), .N(N)) bus0 ();
    multi_adder_sum_if #(.CL_IN(CL_IN), .N(N)) bus1 ();

    assign bus0.d_in  = d_in;
    assign bus0.en_in = en_in;
    assign bus1.d_in  = d_in;
    assign bus1.en_in = en_in;

    multi_adder_sum #(.CL_IN(CL_IN), .RELU(0), .N(N), .SR(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    multi_adder_sum #(.CL_IN(CL_IN), .RELU(1), .N(N), .SR(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent arithmetic model: integer sum, shift, ReLU, clamp
    function automatic logic [2:0] ref_out(input logic [23:0] d, input bit relu);
        int s;
        logic signed [2:0] e;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            e = d[i*3 +: 3];
            s = s + int'(e);
        end
        s = s >>> 2;
        if (relu && s < 0) s = 0;
        if (s > 3) s = 3;
        if (s < -4) s = -4;
        return 3'(s);
    endfunction

    function automatic logic [23:0] stream_vec(input int v);
        logic [23:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*3 +: 3] = 3'((v + i) % 8);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst   = 1'b0;
        en_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d_in = 24'($urandom);
            @(negedge clk);
            n_checks++;
            if (bus0.d_out !== 3'b000 || bus0.en_out !== 1'b0 ||
                bus1.d_out !== 3'b000 || bus1.en_out !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_hold: d_out0=%b en_out0=%b d_out1=%b en_out1=%b required 000/0",
                         bus0.d_out, bus0.en_out, bus1.d_out, bus1.en_out);
            end
        end
        en_in = 1'b0;
        rst   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.en_out !== 1'b0 || bus1.en_out !== 1'b0 || bus0.d_out !== 3'b000) begin
                n_fails++;
                $display("FAIL reset_idle: en_out0=%b en_out1=%b d_out0=%b required 0/0/000",
                         bus0.en_out, bus1.en_out, bus0.d_out);
            end
        end
    endtask

    // Single valid pulse; checks 4-cycle latency, value, then hold with en_out low
    task automatic test_pulse(input string name, input logic [23:0] vec,
                              input logic [2:0] exp0, input logic [2:0] exp1);
        d_in  = vec;
        en_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                en_in = 1'b0;
                d_in  = 24'($urandom);
            end
            if (k == 4) begin
                n_checks++;
                if (bus0.en_out !== 1'b1 || bus0.d_out !== exp0 ||
                    bus1.en_out !== 1'b1 || bus1.d_out !== exp1) begin
                    n_fails++;
                    $display("FAIL %s_result: en0=%b d0=%b en1=%b d1=%b required 1/%b 1/%b",
                             name, bus0.en_out, bus0.d_out, bus1.en_out, bus1.d_out, exp0, exp1);
                end
            end else if (k == 5) begin
                n_checks++;
                if (bus0.en_out !== 1'b0 || bus0.d_out !== exp0 || bus1.d_out !== exp1) begin
                    n_fails++;
                    $display("FAIL %s_hold: en0=%b d0=%b d1=%b required 0/%b/%b",
                             name, bus0.en_out, bus0.d_out, bus1.d_out, exp0, exp1);
                end
            end else begin
                n_checks++;
                if (bus0.en_out !== 1'b0 || bus1.en_out !== 1'b0) begin
                    n_fails++;
                    $display("FAIL %s_early: cycle %0d en0=%b en1=%b required 0",
                             name, k, bus0.en_out, bus1.en_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] v;
        for (int t = 0; t <= 105; t++) begin
            if (t >= 4 && t < 104) begin
                v = stream_vec(t - 4);
                n_checks++;
                if (bus0.en_out !== 1'b1 || bus0.d_out !== ref_out(v, 1'b0) ||
                    bus1.en_out !== 1'b1 || bus1.d_out !== ref_out(v, 1'b1)) begin
                    n_fails++;
                    $display("FAIL stream_%0d: en0=%b d0=%b en1=%b d1=%b required 1/%b 1/%b",
                             t - 4, bus0.en_out, bus0.d_out, bus1.en_out, bus1.d_out,
                             ref_out(v, 1'b0), ref_out(v, 1'b1));
                end
            end else begin
                n_checks++;
                if (bus0.en_out !== 1'b0 || bus1.en_out !== 1'b0) begin
                    n_fails++;
                    $display("FAIL stream_idle_t%0d: en0=%b en1=%b required 0",
                             t, bus0.en_out, bus1.en_out);
                end
            end
            if (t < 100) begin
                d_in  = stream_vec(t);
                en_in = 1'b1;
            end else begin
                en_in = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        for (int t = 0; t < 8; t++) begin
            d_in  = stream_vec(t);
            en_in = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bus0.en_out !== 1'b1 || bus0.d_out !== 3'b111) begin
            n_fails++;
            $display("FAIL midrst_pre: en0=%b d0=%b required 1/111", bus0.en_out, bus0.d_out);
        end
        @(posedge clk);
        #2;
        rst   = 1'b0;
        en_in = 1'b0;
        #1;
        n_checks++;
        if (bus0.en_out !== 1'b0 || bus0.d_out !== 3'b000 ||
            bus1.en_out !== 1'b0 || bus1.d_out !== 3'b000) begin
            n_fails++;
            $display("FAIL midrst_async: en0=%b d0=%b en1=%b d1=%b required 0/000",
                     bus0.en_out, bus0.d_out, bus1.en_out, bus1.d_out);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.en_out !== 1'b0 || bus0.d_out !== 3'b000) begin
                n_fails++;
                $display("FAIL midrst_hold: en0=%b d0=%b required 0/000", bus0.en_out, bus0.d_out);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.en_out !== 1'b0 || bus1.en_out !== 1'b0) begin
                n_fails++;
                $display("FAIL midrst_flush: en0=%b en1=%b required 0", bus0.en_out, bus1.en_out);
            end
        end
        test_pulse("midrst_resume", 24'o11111111, 3'b010, 3'b010);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        en_in    = 1'b0;
        d_in     = '0;

        test_reset();
        test_pulse("basic_ones", 24'o11111111, 3'b010, 3'b010);
        test_pulse("mixed_signs", 24'o07654321, 3'b111, 3'b000);
        test_pulse("sat_pos", 24'o33333333, 3'b011, 3'b011);
        test_pulse("sat_neg", 24'o44444444, 3'b100, 3'b000);
        test_back_to_back();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
